// File: rtl/pixel_pkg.sv
// Shared pixel constants for the drawing datapaths and the plot arbiter.
// Default geometry of the 160x120 VGA adapter and colour/arbitration encodings.
package pixel_pkg;

    localparam int PIX_X_W      = 8;
    localparam int PIX_Y_W      = 7;
    localparam int PIX_COLOUR_W = 24;

    localparam logic [PIX_COLOUR_W-1:0] COLOUR_BLACK = 24'h000000;
    localparam logic [PIX_COLOUR_W-1:0] COLOUR_WHITE = 24'hFFFFFF;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: fixed lowest-index or cyclic from a pointer.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter
    import pixel_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int MODE    = ARB_FIXED,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Scan requests starting at the pointer (or index 0) and take the first hit.
    always_comb begin
        logic           found;
        int             pos;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = (MODE == ARB_RR) ? ((int'(ptr) + k) % NUM_SRC) : k;
            idx = IDX_W'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pixel_plot_arbiter.sv
// Merges several pixel drawers and a rate-limited cursor overlay onto one
// VGA adapter write port, with colour-key transparency per source.
module pixel_plot_arbiter
    import pixel_pkg::*;
#(
    parameter int                    NUM_SRC       = 3,
    parameter int                    X_W           = PIX_X_W,
    parameter int                    Y_W           = PIX_Y_W,
    parameter int                    COLOUR_W      = PIX_COLOUR_W,
    parameter logic [COLOUR_W-1:0]   TRANSPARENT   = '0,
    parameter int                    ARB_MODE      = ARB_FIXED,
    parameter int                    CURSOR_PERIOD = 4,
    parameter logic [COLOUR_W-1:0]   CURSOR_COLOUR = '1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [NUM_SRC*X_W-1:0]           src_x,
    input  logic [NUM_SRC*Y_W-1:0]           src_y,
    input  logic [NUM_SRC*COLOUR_W-1:0]      src_colour,
    input  logic [NUM_SRC-1:0]               src_key_en,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic                             cursor_en,
    input  logic [X_W-1:0]                   cursor_x,
    input  logic [Y_W-1:0]                   cursor_y,
    output logic [X_W-1:0]                   x_out,
    output logic [Y_W-1:0]                   y_out,
    output logic [COLOUR_W-1:0]              colour_out,
    output logic                             plot,
    output logic [$clog2(NUM_SRC+1)-1:0]     out_src,
    output logic [15:0]                      plotted_count
);

    localparam int SRC_W = $clog2(NUM_SRC + 1);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BC_W  = $clog2(CURSOR_PERIOD);

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic [15:0]         count_q, count_d;

    logic [NUM_SRC-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                cursor_slot;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .MODE    (ARB_MODE),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (src_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign cursor_slot = cursor_en &&
        ((burst_cnt_q == BC_W'(CURSOR_PERIOD - 1)) || (src_valid == '0));

    assign src_ready  = (reset || cursor_slot) ? '0 : grant;

    assign sel_x      = src_x[grant_idx*X_W +: X_W];
    assign sel_y      = src_y[grant_idx*Y_W +: Y_W];
    assign sel_colour = src_colour[grant_idx*COLOUR_W +: COLOUR_W];

    // Decide this cycle's slot: cursor, granted source, or idle hold.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        out_src_d   = out_src_q;
        plot_d      = 1'b0;
        burst_cnt_d = '0;
        rr_ptr_d    = rr_ptr_q;
        if (cursor_slot) begin
            x_d       = cursor_x;
            y_d       = cursor_y;
            colour_d  = CURSOR_COLOUR;
            out_src_d = SRC_W'(NUM_SRC);
            plot_d    = 1'b1;
        end else if (src_valid != '0) begin
            x_d       = sel_x;
            y_d       = sel_y;
            colour_d  = sel_colour;
            out_src_d = SRC_W'(grant_idx);
            plot_d    = !(src_key_en[grant_idx] && (sel_colour == TRANSPARENT));
            if (cursor_en) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
            if (ARB_MODE == ARB_RR) begin
                rr_ptr_d = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
        count_d = count_q + {15'b0, plot_d};
    end

    // Register the decided pixel and arbitration state.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            out_src_q   <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            out_src_q   <= out_src_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign colour_out    = colour_q;
    assign plot          = plot_q;
    assign out_src       = out_src_q;
    assign plotted_count = count_q;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Scoreboard bench for pixel_plot_arbiter in fixed and round-robin modes.
// Both instances see identical stimulus; each has its own expectation queue.
module tb_pixel_plot_arbiter;
    import pixel_pkg::*;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 24;
    localparam int P  = 4;
    localparam int SW = 2;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic          plot;
        logic [SW-1:0] src;
        logic [15:0]   cnt;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_key_en;
    logic [N*XW-1:0] src_x;
    logic [N*YW-1:0] src_y;
    logic [N*CW-1:0] src_colour;
    logic            cursor_en;
    logic [XW-1:0]   cursor_x;
    logic [YW-1:0]   cursor_y;
    logic [XW-1:0]   sx [N];
    logic [YW-1:0]   sy [N];
    logic [CW-1:0]   sc [N];

    logic [N-1:0]  rdy0, rdy1;
    logic [XW-1:0] xo0, xo1;
    logic [YW-1:0] yo0, yo1;
    logic [CW-1:0] co0, co1;
    logic          pl0, pl1;
    logic [SW-1:0] os0, os1;
    logic [15:0]   cn0, cn1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m_o[2];
    int   m_ptr[2];
    int   m_burst[2];
    int   passed = 0;
    int   total  = 0;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign src_x[i*XW +: XW]      = sx[i];
        assign src_y[i*YW +: YW]      = sy[i];
        assign src_colour[i*CW +: CW] = sc[i];
    end

    always #5 clock = ~clock;

    pixel_plot_arbiter #(.ARB_MODE(ARB_FIXED), .CURSOR_PERIOD(P)) dut_fx (
        .clock(clock), .reset(reset), .src_valid(src_valid), .src_x(src_x),
        .src_y(src_y), .src_colour(src_colour), .src_key_en(src_key_en),
        .src_ready(rdy0), .cursor_en(cursor_en), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .x_out(xo0), .y_out(yo0), .colour_out(co0),
        .plot(pl0), .out_src(os0), .plotted_count(cn0)
    );

    pixel_plot_arbiter #(.ARB_MODE(ARB_RR), .CURSOR_PERIOD(P)) dut_rr (
        .clock(clock), .reset(reset), .src_valid(src_valid), .src_x(src_x),
        .src_y(src_y), .src_colour(src_colour), .src_key_en(src_key_en),
        .src_ready(rdy1), .cursor_en(cursor_en), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .x_out(xo1), .y_out(yo1), .colour_out(co1),
        .plot(pl1), .out_src(os1), .plotted_count(cn1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Predict one cycle for instance m; check its ready and queue the outputs.
    task automatic predict(input int m);
        logic         cs;
        int           g;
        int           idx;
        logic [N-1:0] er;
        logic [N-1:0] obs;
        cs = cursor_en && (m_burst[m] == P - 1 || src_valid == 0);
        g  = -1;
        if (!reset && !cs) begin
            for (int k = 0; k < N; k++) begin
                idx = (m == 1) ? (m_ptr[m] + k) % N : k;
                if (g < 0 && src_valid[idx]) g = idx;
            end
        end
        er  = (g >= 0) ? N'(1 << g) : '0;
        obs = (m == 0) ? rdy0 : rdy1;
        chk(m == 0 ? "fx_ready" : "rr_ready", 32'(obs), 32'(er));
        if (reset) begin
            m_o[m].x    = '0;
            m_o[m].y    = '0;
            m_o[m].c    = '0;
            m_o[m].plot = 1'b0;
            m_o[m].src  = '0;
            m_o[m].cnt  = '0;
            m_ptr[m]    = 0;
            m_burst[m]  = 0;
        end else begin
            if (cs) begin
                m_o[m].x    = cursor_x;
                m_o[m].y    = cursor_y;
                m_o[m].c    = 24'hFFFFFF;
                m_o[m].plot = 1'b1;
                m_o[m].src  = SW'(N);
                m_burst[m]  = 0;
            end else if (g >= 0) begin
                m_o[m].x    = sx[g];
                m_o[m].y    = sy[g];
                m_o[m].c    = sc[g];
                m_o[m].plot = !(src_key_en[g] && sc[g] == 24'd0);
                m_o[m].src  = SW'(g);
                m_burst[m]  = cursor_en ? m_burst[m] + 1 : 0;
                if (m == 1) m_ptr[m] = (g + 1) % N;
            end else begin
                m_o[m].plot = 1'b0;
                m_burst[m]  = 0;
            end
            if (m_o[m].plot) m_o[m].cnt = m_o[m].cnt + 16'd1;
        end
        if (m == 0) q0.push_back(m_o[m]);
        else        q1.push_back(m_o[m]);
    endtask

    task automatic step();
        exp_t e;
        #1;
        predict(0);
        predict(1);
        @(posedge clock);
        #1;
        e = q0.pop_front();
        chk("fx_x", 32'(xo0), 32'(e.x));
        chk("fx_y", 32'(yo0), 32'(e.y));
        chk("fx_colour", 32'(co0), 32'(e.c));
        chk("fx_plot", 32'(pl0), 32'(e.plot));
        chk("fx_src", 32'(os0), 32'(e.src));
        chk("fx_count", 32'(cn0), 32'(e.cnt));
        e = q1.pop_front();
        chk("rr_x", 32'(xo1), 32'(e.x));
        chk("rr_y", 32'(yo1), 32'(e.y));
        chk("rr_colour", 32'(co1), 32'(e.c));
        chk("rr_plot", 32'(pl1), 32'(e.plot));
        chk("rr_src", 32'(os1), 32'(e.src));
        chk("rr_count", 32'(cn1), 32'(e.cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset      = 1'b1;
        src_valid  = '1;
        src_key_en = '0;
        cursor_en  = 1'b0;
        cursor_x   = 8'd10;
        cursor_y   = 7'd20;
        for (int i = 0; i < N; i++) begin
            sx[i] = XW'(11 * (i + 1));
            sy[i] = YW'(3 * (i + 1));
            sc[i] = CW'(24'h100000 * (i + 1) + 24'h55);
        end
        @(posedge clock);
        #1;
        run(2);
        chk("rst_x", 32'(xo0), 32'd0);
        chk("rst_count", 32'(cn0), 32'd0);

        reset = 1'b0;
        run(5);
        chk("fx_count5", 32'(cn0), 32'd5);
        chk("fx_src0", 32'(os0), 32'd0);

        reset = 1'b1;
        run(1);
        reset     = 1'b0;
        src_valid = 3'b101;
        run(4);
        chk("rr_last_src2", 32'(os1), 32'd2);

        src_valid = 3'b001;
        cursor_en = 1'b1;
        run(8);
        chk("cur_src", 32'(os0), 32'd3);
        chk("cur_colour", 32'(co0), 32'hFFFFFF);

        cursor_en  = 1'b0;
        src_valid  = 3'b010;
        src_key_en = 3'b010;
        sx[1] = 8'd5;
        sy[1] = 7'd6;
        sc[1] = 24'd0;
        run(1);
        chk("key_plot", 32'(pl0), 32'd0);
        chk("key_x", 32'(xo0), 32'd5);
        src_key_en = 3'b000;
        run(1);
        chk("nokey_plot", 32'(pl0), 32'd1);

        src_valid = 3'b001;
        sx[0] = 8'd7;
        sy[0] = 7'd8;
        run(1);
        src_valid = 3'b000;
        run(3);
        chk("idle_x", 32'(xo0), 32'd7);
        chk("idle_y", 32'(yo0), 32'd8);
        cursor_en = 1'b1;
        run(3);
        chk("idle_cur", 32'(os0), 32'd3);

        for (int i = 0; i < 60; i++) begin
            reset      = ($urandom_range(0, 29) == 0);
            src_valid  = N'($urandom);
            src_key_en = N'($urandom);
            cursor_en  = ($urandom_range(0, 9) < 6);
            cursor_x   = XW'($urandom);
            cursor_y   = YW'($urandom);
            for (int s = 0; s < N; s++) begin
                sx[s] = XW'($urandom);
                sy[s] = YW'($urandom);
                sc[s] = ($urandom_range(0, 2) == 0) ? 24'd0 : CW'($urandom);
            end
            run(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
